// File: rtl/div_32bit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock,
// quotient returned as LO and remainder as HI, with a start/busy/done handshake.
module div_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic [CW-1:0]    r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dvz;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_dvz;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  always_comb begin
    w_a_neg = is_signed & dividend[WIDTH-1];
    w_b_neg = is_signed & divisor[WIDTH-1];
    w_a_mag = w_a_neg ? -dividend : dividend;
    w_b_mag = w_b_neg ? -divisor  : divisor;
    w_dvz   = (divisor == '0);
    // 33-bit trial subtract: bit WIDTH set means the shifted remainder was below the divisor
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_dvsr};
    w_q_fix = r_q_neg ? -r_quo : r_quo;
    w_r_fix = r_r_neg ? -r_rem : r_rem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvsr      <= '0;
      r_cnt       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_dvz       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // On a zero divisor r_quo carries the raw dividend straight to FIN
            r_quo   <= w_dvz ? dividend : w_a_mag;
            r_rem   <= '0;
            r_dvsr  <= w_b_mag;
            r_cnt   <= '0;
            r_q_neg <= w_a_neg ^ w_b_neg;
            r_r_neg <= w_a_neg;
            r_dvz   <= w_dvz;
            busy    <= 1'b1;
            r_state <= w_dvz ? S_FIN : S_RUN;
          end
        end
        S_RUN: begin
          r_rem   <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
          r_quo   <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIN;
        end
        S_FIN: begin
          if (r_dvz) begin
            quotient  <= '1;
            remainder <= r_quo;
          end else begin
            quotient  <= w_q_fix;
            remainder <= w_r_fix;
          end
          div_by_zero <= r_dvz;
          done        <= 1'b1;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32bit.sv
// Self-checking bench for div_32bit: directed corner cases plus random
// operations compared against a plain-arithmetic DIV/DIVU model.
module tb_div_32bit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  div_32bit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // MIPS DIV/DIVU reference: truncating division, remainder follows dividend sign
  task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      dz = 1'b0;
    end
  endtask

  // Drives start for one edge (E0); returns #1 after E0 with operands scrambled
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom);
  endtask

  // Waits for done from #1 after E0; optionally injects a start at edge inject_at
  task automatic wait_done(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int inject_at);
    logic [31:0] eq, er;
    logic        edz;
    int          edges, busy_cnt, exp_lat;
    ref_div(sgn, a, b, eq, er, edz);
    exp_lat  = (b == 32'd0) ? 1 : 33;
    edges    = 0;
    busy_cnt = 0;
    while (!done && edges < 60) begin
      if (busy) busy_cnt++;
      if (edges == inject_at - 1) begin
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd50;
        divisor   = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
    end
    start = 1'b0;
    check({tag, ".done"},    {31'd0, done}, 32'd1);
    check({tag, ".latency"}, edges, exp_lat);
    check({tag, ".busycyc"}, busy_cnt, exp_lat);
    check({tag, ".busy0"},   {31'd0, busy}, 32'd0);
    check({tag, ".q"},       quotient, eq);
    check({tag, ".r"},       remainder, er);
    check({tag, ".dz"},      {31'd0, div_by_zero}, {31'd0, edz});
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    start_op(sgn, a, b);
    check({tag, ".done_clr"}, {31'd0, done}, 32'd0);
    wait_done(tag, sgn, a, b, 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          stray;

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.q",    quotient, 32'd0);
    check("rst.r",    remainder, 32'd0);
    check("rst.dz",   {31'd0, div_by_zero}, 32'd0);

    run_op("u100_7",  1'b0, 32'd100, 32'd7);
    run_op("s-7_2",   1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("s7_-2",   1'b1, 32'd7, 32'hFFFF_FFFE);
    run_op("s-7_-2",  1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
    run_op("uF9_2",   1'b0, 32'hFFFF_FFF9, 32'd2);
    run_op("s5_0",    1'b1, 32'd5, 32'd0);
    run_op("u5_0",    1'b0, 32'd5, 32'd0);
    run_op("u9_3",    1'b0, 32'd9, 32'd3);
    run_op("s-5_0",   1'b1, 32'hFFFF_FFFB, 32'd0);
    run_op("sovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("uovf",    1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("umax",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("umaxdv",  1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF);

    // start while busy at E5 is ignored; a start in the done cycle is accepted
    start_op(1'b0, 32'd1000, 32'd10);
    wait_done("ign", 1'b0, 32'd1000, 32'd10, 5);
    start_op(1'b1, 32'hFFFF_FC18, 32'd7);
    wait_done("b2b", 1'b1, 32'hFFFF_FC18, 32'd7, 0);

    // reset at E12 discards the running operation
    start_op(1'b1, 32'hFFFE_1DC0, 32'd789);
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mrst.busy", {31'd0, busy}, 32'd0);
    check("mrst.done", {31'd0, done}, 32'd0);
    check("mrst.q",    quotient, 32'd0);
    check("mrst.r",    remainder, 32'd0);
    check("mrst.dz",   {31'd0, div_by_zero}, 32'd0);
    stray = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) stray++;
    end
    check("mrst.nodone", stray, 32'd0);
    run_op("post_rst", 1'b1, 32'hFFFE_1DC0, 32'd789);

    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case (i % 4)
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 255));
        2:       rb = -32'($urandom_range(1, 255));
        default: rb = (i == 7) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      run_op($sformatf("rnd%0d", i), rs, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_32bit.md
Name: div_32bit

Overview:
- Iterative 32-bit integer divider for the MIPS datapath; executes DIV/DIVU.
- Produces quotient (LO) and remainder (HI) from a dividend and divisor.
- One restoring-division step per clock; start/busy/done handshake.
- Sits beside the combinational ALU logic/arith units; the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is verified.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- dividend  input  32  sampled with start
- divisor  input  32  sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  32  held until the next done
- remainder  output  32  held until the next done
- div_by_zero  output  1  flag for the last completed operation; held with the results

Behaviour:
- Reset, clocked on the edge with reset=1:
  - state=IDLE; busy, done, div_by_zero=0; quotient, remainder=0.
  - Reset overrides everything, including mid-RUN: the operation is discarded and no done follows.
- States: IDLE, RUN, FIN.
- IDLE, start=1 at edge E0:
  - Latch the operands and is_signed.
  - If signed, convert both operands to magnitudes and record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
  - Divisor==0: go to FIN directly, skipping RUN.
  - Otherwise: go to RUN with iteration count=0.
- RUN, one step per edge:
  - Shift {partial remainder, quotient} left by 1.
  - Trial-subtract the divisor magnitude using a 33-bit subtract.
  - If the result is non-negative, keep it and set quotient LSB=1.
  - After 32 steps (edge E32), go to FIN.
- FIN, one cycle, then IDLE at the next edge. At that edge:
  - Apply sign correction.
  - Register quotient/remainder/div_by_zero.
  - Set done=1.
- done is 1 for exactly one cycle and clears on the following edge.
- Latency, nonzero divisor:
  - busy=1 in the 33 cycles after E0..E32.
  - Results and done appear after E33.
  - busy=0 in the done cycle.
- Latency, divide-by-zero: busy=1 for 1 cycle; done/results after E1.
- Signed semantics:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - dividend == quotient*divisor + remainder holds.
- Divide-by-zero result: quotient=32'hFFFFFFFF, remainder=dividend as sampled (raw, not magnitude), div_by_zero=1. Applies to both signed and unsigned.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, div_by_zero=0. No trap.
- start while busy: ignored; the inputs are not re-sampled and the running operation is unaffected.
- start in the done cycle: accepted (state is IDLE); the new operation begins normally.
- Operand inputs may change freely after E0 without effect.
- div_by_zero is cleared by the next completed nonzero-divisor operation.

Test Plan:
1. Unsigned 100 / 7, start at E0 → busy high 33 cycles; done after E33; quotient=14, remainder=2, div_by_zero=0.
2. Signed sign combinations:
   - -7/2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
   - 7/-2 → quotient=0xFFFFFFFD, remainder=1.
   - -7/-2 → quotient=3, remainder=0xFFFFFFFF.
   - Same bits as unsigned 0xFFFFFFF9/2 → quotient=0x7FFFFFFC, remainder=1.
3. 5/0, signed and unsigned → done after E1; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. A following 9/3 → quotient=3, remainder=0, div_by_zero=0.
4. Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. Unsigned same operands → quotient=0, remainder=0x80000000.
5. start at E0 for 1000/10, then:
   - start=1 with 50/5 at E5 → ignored; result quotient=100, remainder=0.
   - New start asserted in the done cycle → accepted; its done arrives 33 edges later.
6. reset=1 at E12 mid-RUN → next cycle busy=0, done=0, quotient=0, remainder=0; no done pulse follows. A new start afterwards completes correctly.
